// File: rtl/conv_result_serializer.sv
`default_nettype none
// ============================================================================
// Module   : conv_result_serializer
// Purpose  : Captures a complete convolution result frame (flattened bus) into
//            a shadow register on in_valid and replays it, word 0 first, as
//            signed 2*WORD_LENGTH words over a ready/valid stream. Optional
//            ReLU clamps negative words to zero on the way out.
// Ports    : clk, rst (async, active-high)
//            in_valid      - one-cycle pulse: data_in holds a full frame
//            data_in       - N words, word i at [(i+1)*WW-1 -: WW]
//            out_ready     - downstream ready
//            out_data      - registered result word
//            out_valid     - registered valid for out_data
//            out_last      - high with the final word (index N-1)
//            busy          - a frame is held or being streamed
//            frame_dropped - one-cycle pulse after a rejected in_valid
// Revision : 1.0 - initial release
// ============================================================================
module conv_result_serializer #(
  parameter int WORD_LENGTH = 8,
  parameter int KERNEL_SIZE = 5,
  parameter int IMAGE_SIZE  = 36,
  parameter bit RELU_EN     = 1'b0,
  localparam int OUT_SIZE   = IMAGE_SIZE - (KERNEL_SIZE - KERNEL_SIZE % 2),
  localparam int N          = OUT_SIZE * OUT_SIZE,
  localparam int WW         = 2 * WORD_LENGTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [N*WW-1:0]   data_in,
  input  logic              out_ready,
  output logic [WW-1:0]     out_data,
  output logic              out_valid,
  output logic              out_last,
  output logic              busy,
  output logic              frame_dropped
);

  localparam logic [15:0] c_LAST_IDX = 16'(N - 1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t            r_state;
  logic [N*WW-1:0]   r_shadow;
  logic [15:0]       r_index;
  logic [WW-1:0]     r_out_data;
  logic              r_out_valid;
  logic              r_out_last;
  logic              r_busy;
  logic              r_dropped;

  state_t            w_state_nxt;
  logic [N*WW-1:0]   w_shadow_nxt;
  logic [15:0]       w_index_nxt;
  logic [WW-1:0]     w_data_nxt;
  logic              w_valid_nxt;
  logic              w_last_nxt;
  logic              w_busy_nxt;
  logic              w_dropped_nxt;
  logic              w_capture;
  logic              w_xfer;
  logic              w_final;
  logic [15:0]       w_index_inc;

  function automatic logic [WW-1:0] f_relu(input logic [WW-1:0] w);
    return (RELU_EN && w[WW-1]) ? '0 : w;
  endfunction

  assign w_xfer      = r_out_valid && out_ready;
  assign w_final     = w_xfer && (r_index == c_LAST_IDX);
  assign w_index_inc = r_index + 16'd1;

  always_comb begin
    w_state_nxt   = r_state;
    w_shadow_nxt  = r_shadow;
    w_index_nxt   = r_index;
    w_data_nxt    = r_out_data;
    w_valid_nxt   = r_out_valid;
    w_last_nxt    = r_out_last;
    w_busy_nxt    = r_busy;
    w_dropped_nxt = 1'b0;
    w_capture     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_capture = 1'b1;
        end
      end
      S_STREAM: begin
        if (w_final) begin
          // A new frame arriving on the final handshake chains straight on,
          // so back-to-back frames have no bubble between them.
          if (in_valid) begin
            w_capture = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_index_nxt = '0;
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
            w_busy_nxt  = 1'b0;
          end
        end else if (w_xfer) begin
          w_index_nxt = w_index_inc;
          w_data_nxt  = f_relu(r_shadow[w_index_inc * WW +: WW]);
          w_last_nxt  = (w_index_inc == c_LAST_IDX);
        end
        if (in_valid && !w_final) begin
          w_dropped_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_capture) begin
      // Word 0 is taken straight from the bus so it is presented on the
      // same edge that loads the shadow register.
      w_state_nxt  = S_STREAM;
      w_shadow_nxt = data_in;
      w_index_nxt  = '0;
      w_data_nxt   = f_relu(data_in[WW-1:0]);
      w_valid_nxt  = 1'b1;
      w_last_nxt   = (N == 1);
      w_busy_nxt   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_shadow    <= '0;
      r_index     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_dropped   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shadow    <= w_shadow_nxt;
      r_index     <= w_index_nxt;
      r_out_data  <= w_data_nxt;
      r_out_valid <= w_valid_nxt;
      r_out_last  <= w_last_nxt;
      r_busy      <= w_busy_nxt;
      r_dropped   <= w_dropped_nxt;
    end
  end

  assign out_data      = r_out_data;
  assign out_valid     = r_out_valid;
  assign out_last      = r_out_last;
  assign busy          = r_busy;
  assign frame_dropped = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_conv_result_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_result_serializer
// Purpose  : Directed self-checking bench for conv_result_serializer with
//            IMAGE_SIZE=8, KERNEL_SIZE=5 (N=16). A second instance with ReLU
//            enabled shares all inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_result_serializer;

  localparam int N  = 16;
  localparam int WW = 16;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic [N*WW-1:0] data_in;
  logic            out_ready;
  logic [WW-1:0]   out_data;
  logic            out_valid;
  logic            out_last;
  logic            busy;
  logic            frame_dropped;
  logic [WW-1:0]   r_out_data;
  logic            r_out_valid;
  logic            r_out_last;
  logic            r_busy;
  logic            r_frame_dropped;

  int checks;
  int errors;

  logic [N*WW-1:0] frame_a;
  logic [N*WW-1:0] frame_b;

  conv_result_serializer #(
    .WORD_LENGTH(8), .KERNEL_SIZE(5), .IMAGE_SIZE(8), .RELU_EN(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
    .out_ready(out_ready), .out_data(out_data), .out_valid(out_valid),
    .out_last(out_last), .busy(busy), .frame_dropped(frame_dropped)
  );

  conv_result_serializer #(
    .WORD_LENGTH(8), .KERNEL_SIZE(5), .IMAGE_SIZE(8), .RELU_EN(1'b1)
  ) dut_relu (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
    .out_ready(out_ready), .out_data(r_out_data), .out_valid(r_out_valid),
    .out_last(r_out_last), .busy(r_busy), .frame_dropped(r_frame_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*WW-1:0] mk_frame(input int base, input int step);
    logic [N*WW-1:0] f;
    f = '0;
    for (int i = 0; i < N; i++) f[i*WW +: WW] = 16'(base + step * i);
    return f;
  endfunction

  // Word i of frame A is 3i-20; of frame B is 100+i.
  function automatic logic [31:0] exp_a(input int i);
    return {16'd0, 16'(3 * i - 20)};
  endfunction

  function automatic logic [31:0] exp_a_relu(input int i);
    return (3 * i - 20 < 0) ? 32'd0 : {16'd0, 16'(3 * i - 20)};
  endfunction

  initial begin
    checks    = 0;
    errors    = 0;
    frame_a   = mk_frame(-20, 3);
    frame_b   = mk_frame(100, 1);
    rst       = 1'b1;
    in_valid  = 1'b0;
    data_in   = '0;
    out_ready = 1'b0;

    // ---- Reset values
    #1;
    check("rst_data",    {16'd0, out_data}, 32'd0);
    check("rst_valid",   {31'd0, out_valid}, 32'd0);
    check("rst_last",    {31'd0, out_last}, 32'd0);
    check("rst_busy",    {31'd0, busy}, 32'd0);
    check("rst_dropped", {31'd0, frame_dropped}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // ---- Full-rate stream, plain and ReLU instances together
    @(negedge clk);
    check("idle_valid", {31'd0, out_valid}, 32'd0);
    in_valid  = 1'b1;
    data_in   = frame_a;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("s2_valid[%0d]", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("s2_data[%0d]", i),  {16'd0, out_data}, exp_a(i));
      check($sformatf("s2_last[%0d]", i),  {31'd0, out_last}, (i == N - 1) ? 32'd1 : 32'd0);
      check($sformatf("s2_busy[%0d]", i),  {31'd0, busy}, 32'd1);
      check($sformatf("s4_relu[%0d]", i),  {16'd0, r_out_data}, exp_a_relu(i));
      check($sformatf("s4_rvalid[%0d]", i), {31'd0, r_out_valid}, 32'd1);
    end
    @(negedge clk);
    check("s2_end_valid", {31'd0, out_valid}, 32'd0);
    check("s2_end_last",  {31'd0, out_last}, 32'd0);
    check("s2_end_busy",  {31'd0, busy}, 32'd0);
    check("s4_end_busy",  {31'd0, r_busy}, 32'd0);

    // ---- Back-pressure with ready pattern 1,0,0,1
    begin
      logic [3:0] pat;
      int         got;
      int         cyc;
      pat = 4'b1001;
      got = 0;
      cyc = 0;
      in_valid = 1'b1;
      data_in  = frame_a;
      @(negedge clk);
      in_valid = 1'b0;
      while (got < N && cyc < 100) begin
        out_ready = pat[cyc % 4];
        check($sformatf("s3_valid[c%0d]", cyc), {31'd0, out_valid}, 32'd1);
        check($sformatf("s3_data[c%0d]", cyc),  {16'd0, out_data}, exp_a(got));
        check($sformatf("s3_last[c%0d]", cyc),  {31'd0, out_last}, (got == N - 1) ? 32'd1 : 32'd0);
        if (out_ready) got++;
        cyc++;
        @(negedge clk);
      end
      check("s3_count", got, N);
      check("s3_end_busy", {31'd0, busy}, 32'd0);
    end

    // ---- Drop while streaming, then chained frame on the final transfer
    out_ready = 1'b1;
    in_valid  = 1'b1;
    data_in   = frame_a;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("s5_data[%0d]", i),    {16'd0, out_data}, exp_a(i));
      check($sformatf("s5_dropped[%0d]", i), {31'd0, frame_dropped}, (i == 6) ? 32'd1 : 32'd0);
      check($sformatf("s5_busy[%0d]", i),    {31'd0, busy}, 32'd1);
      if (i == 5 || i == N - 1) begin
        in_valid = 1'b1;
        data_in  = frame_b;
      end
    end
    for (int j = 0; j < N; j++) begin
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("s5b_data[%0d]", j),  {16'd0, out_data}, 32'(100 + j));
      check($sformatf("s5b_valid[%0d]", j), {31'd0, out_valid}, 32'd1);
      check($sformatf("s5b_busy[%0d]", j),  {31'd0, busy}, 32'd1);
      if (j == 0) check("s5b_nodrop", {31'd0, frame_dropped}, 32'd0);
    end
    @(negedge clk);
    check("s5_end_busy", {31'd0, busy}, 32'd0);

    // ---- Asynchronous reset mid-stream while stalled at index 7
    in_valid = 1'b1;
    data_in  = frame_a;
    for (int i = 0; i <= 7; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("s6_data[%0d]", i), {16'd0, out_data}, exp_a(i));
      if (i == 7) out_ready = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    check("s6_rst_data",    {16'd0, out_data}, 32'd0);
    check("s6_rst_valid",   {31'd0, out_valid}, 32'd0);
    check("s6_rst_last",    {31'd0, out_last}, 32'd0);
    check("s6_rst_busy",    {31'd0, busy}, 32'd0);
    check("s6_rst_dropped", {31'd0, frame_dropped}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("s6_idle_valid", {31'd0, out_valid}, 32'd0);
    in_valid  = 1'b1;
    data_in   = frame_b;
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("s6b_data[%0d]", j), {16'd0, out_data}, 32'(100 + j));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
